// File: rtl/average_job_sequencer.sv
// rtl/average_job_sequencer.sv - host-side job sequencer for the average accelerator
//
// Purpose:
//   Accepts one job (count, index_hi, index_lo) on a valid/ready port, programs the
//   accelerator config registers over the MMR bus, pulses core_start, waits for
//   core_done (with a cycle-count timeout), reads the result register and returns
//   result plus status on a valid/ready response port. One job in flight at a time.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   i_job_valid / o_job_ready   job handshake; ready is high only in IDLE
//   i_job_count/_index_hi/_lo   job fields, written to 0x10 / 0x14 / 0x18
//   o_rsp_valid / i_rsp_ready   response handshake; valid held until ready
//   o_rsp_result, o_rsp_status  result of 0x1C read; status 00 OK, 01 bus error, 10 timeout
//   o_mmr_*                     MMR master strobes, address and write data
//   i_mmr_rdata                 read data, valid the cycle after o_mmr_ren
//   i_mmr_waddr_error           write error, valid the cycle after o_mmr_wen
//   i_mmr_raddr_error           read error, valid the cycle after o_mmr_ren
//   o_core_start, i_core_done   core start pulse and completion
//   i_abort                     synchronous abort of the in-flight job
//   o_busy                      high whenever the FSM is not in IDLE

module average_job_sequencer #(
  parameter int ADDR_BITS      = 12,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 i_job_valid,
  output logic                 o_job_ready,
  input  logic [DATA_BITS-1:0] i_job_count,
  input  logic [DATA_BITS-1:0] i_job_index_hi,
  input  logic [DATA_BITS-1:0] i_job_index_lo,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATA_BITS-1:0] o_rsp_result,
  output logic [1:0]           o_rsp_status,
  output logic [ADDR_BITS-1:0] o_mmr_addr,
  output logic                 o_mmr_wen,
  output logic [DATA_BITS-1:0] o_mmr_wdata,
  output logic                 o_mmr_ren,
  input  logic [DATA_BITS-1:0] i_mmr_rdata,
  input  logic                 i_mmr_waddr_error,
  input  logic                 i_mmr_raddr_error,
  output logic                 o_core_start,
  input  logic                 i_core_done,
  input  logic                 i_abort,
  output logic                 o_busy
);

  localparam logic [ADDR_BITS-1:0] ADDR_CNT = ADDR_BITS'(16'h0010);
  localparam logic [ADDR_BITS-1:0] ADDR_HI  = ADDR_BITS'(16'h0014);
  localparam logic [ADDR_BITS-1:0] ADDR_LO  = ADDR_BITS'(16'h0018);
  localparam logic [ADDR_BITS-1:0] ADDR_RES = ADDR_BITS'(16'h001C);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CNT,
    S_WR_HI,
    S_WR_LO,
    S_CHK,
    S_START,
    S_WAIT_DONE,
    S_RD_REQ,
    S_RD_DAT,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_hi;
  logic [DATA_BITS-1:0] r_lo;
  logic                 r_err;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_rsp_valid;
  logic [DATA_BITS-1:0] r_rsp_result;
  logic [1:0]           r_rsp_status;
  logic [ADDR_BITS-1:0] r_mmr_addr;
  logic                 r_mmr_wen;
  logic [DATA_BITS-1:0] r_mmr_wdata;
  logic                 r_mmr_ren;
  logic                 r_core_start;

  logic                 w_abort;

  // Abort only matters while a job is being driven onto the bus or the core;
  // IDLE has nothing to cancel and RESP must deliver what it already holds.
  assign w_abort = i_abort && (r_state != S_IDLE) && (r_state != S_RESP);

  assign o_job_ready  = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_status = r_rsp_status;
  assign o_mmr_addr   = r_mmr_addr;
  assign o_mmr_wen    = r_mmr_wen;
  assign o_mmr_wdata  = r_mmr_wdata;
  assign o_mmr_ren    = r_mmr_ren;
  assign o_core_start = r_core_start;

  // Strobes are registered and loaded on the edge that enters the state they
  // belong to, so each state sees its own strobe during its single cycle.
  // The count field goes straight from the input to the bus; only the two
  // index fields need holding for later cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_hi         <= '0;
      r_lo         <= '0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_status <= ST_OK;
      r_mmr_addr   <= '0;
      r_mmr_wen    <= 1'b0;
      r_mmr_wdata  <= '0;
      r_mmr_ren    <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      // Bus and start strobes are single-cycle; address/data return to 0
      // whenever no enable is asserted.
      r_mmr_wen    <= 1'b0;
      r_mmr_ren    <= 1'b0;
      r_mmr_addr   <= '0;
      r_mmr_wdata  <= '0;
      r_core_start <= 1'b0;

      if (w_abort) begin
        r_state <= S_IDLE;
        r_err   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_job_valid) begin
              r_hi        <= i_job_index_hi;
              r_lo        <= i_job_index_lo;
              r_err       <= 1'b0;
              r_mmr_wen   <= 1'b1;
              r_mmr_addr  <= ADDR_CNT;
              r_mmr_wdata <= i_job_count;
              r_state     <= S_WR_CNT;
            end
          end

          S_WR_CNT: begin
            r_mmr_wen   <= 1'b1;
            r_mmr_addr  <= ADDR_HI;
            r_mmr_wdata <= r_hi;
            r_state     <= S_WR_HI;
          end

          // Error flag seen here belongs to the 0x10 write.
          S_WR_HI: begin
            r_err       <= r_err | i_mmr_waddr_error;
            r_mmr_wen   <= 1'b1;
            r_mmr_addr  <= ADDR_LO;
            r_mmr_wdata <= r_lo;
            r_state     <= S_WR_LO;
          end

          // Error flag seen here belongs to the 0x14 write.
          S_WR_LO: begin
            r_err   <= r_err | i_mmr_waddr_error;
            r_state <= S_CHK;
          end

          // Error flag seen here belongs to the 0x18 write, so it is folded in
          // directly rather than waiting a cycle for the sticky bit.
          S_CHK: begin
            if (r_err || i_mmr_waddr_error) begin
              r_err        <= 1'b1;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_BUS_ERR;
              r_rsp_result <= '0;
              r_state      <= S_RESP;
            end else begin
              r_core_start <= 1'b1;
              r_state      <= S_START;
            end
          end

          S_START: begin
            r_cnt   <= '0;
            r_state <= S_WAIT_DONE;
          end

          // done is tested first so it wins over the timeout in the same cycle.
          S_WAIT_DONE: begin
            if (i_core_done) begin
              r_mmr_ren  <= 1'b1;
              r_mmr_addr <= ADDR_RES;
              r_state    <= S_RD_REQ;
            end else if (r_cnt == TO_LAST) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= ST_TIMEOUT;
              r_rsp_result <= '0;
              r_state      <= S_RESP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end

          S_RD_REQ: begin
            r_state <= S_RD_DAT;
          end

          S_RD_DAT: begin
            r_rsp_valid <= 1'b1;
            if (i_mmr_raddr_error) begin
              r_rsp_status <= ST_BUS_ERR;
              r_rsp_result <= '0;
            end else begin
              r_rsp_status <= ST_OK;
              r_rsp_result <= i_mmr_rdata;
            end
            r_state <= S_RESP;
          end

          // Result/status are untouched here, so they stay stable under backpressure.
          S_RESP: begin
            if (i_rsp_ready) begin
              r_rsp_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_average_job_sequencer.sv
// tb/tb_average_job_sequencer.sv - directed self-checking bench for average_job_sequencer

module tb_average_job_sequencer;

  logic        clk = 1'b0;
  logic        arst_n;
  always #5 clk = ~clk;

  // main instance (TIMEOUT_CYCLES = 16)
  logic        job_valid = 1'b0, job_ready;
  logic [31:0] job_count = '0, job_hi = '0, job_lo = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_status;
  logic [11:0] mmr_addr;
  logic        mmr_wen, mmr_ren;
  logic [31:0] mmr_wdata;
  logic [31:0] mmr_rdata = '0;
  logic        waddr_error = 1'b0, raddr_error = 1'b0;
  logic        core_start, core_done, abort = 1'b0, busy;

  // timeout instance (TIMEOUT_CYCLES = 8)
  logic        to_job_valid = 1'b0, to_job_ready;
  logic        to_rsp_valid, to_rsp_ready = 1'b0;
  logic [31:0] to_rsp_result;
  logic [1:0]  to_rsp_status;
  logic [11:0] to_mmr_addr;
  logic        to_mmr_wen, to_mmr_ren;
  logic [31:0] to_mmr_wdata;
  logic        to_core_start, to_core_done = 1'b0, to_busy;

  average_job_sequencer #(.ADDR_BITS(12), .DATA_BITS(32), .TIMEOUT_W(16), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .arst_n(arst_n),
    .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_count(job_count), .i_job_index_hi(job_hi), .i_job_index_lo(job_lo),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_result(rsp_result), .o_rsp_status(rsp_status),
    .o_mmr_addr(mmr_addr), .o_mmr_wen(mmr_wen), .o_mmr_wdata(mmr_wdata), .o_mmr_ren(mmr_ren),
    .i_mmr_rdata(mmr_rdata), .i_mmr_waddr_error(waddr_error), .i_mmr_raddr_error(raddr_error),
    .o_core_start(core_start), .i_core_done(core_done), .i_abort(abort), .o_busy(busy)
  );

  average_job_sequencer #(.ADDR_BITS(12), .DATA_BITS(32), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)) u_dut_to (
    .clk(clk), .arst_n(arst_n),
    .i_job_valid(to_job_valid), .o_job_ready(to_job_ready),
    .i_job_count(job_count), .i_job_index_hi(job_hi), .i_job_index_lo(job_lo),
    .o_rsp_valid(to_rsp_valid), .i_rsp_ready(to_rsp_ready),
    .o_rsp_result(to_rsp_result), .o_rsp_status(to_rsp_status),
    .o_mmr_addr(to_mmr_addr), .o_mmr_wen(to_mmr_wen), .o_mmr_wdata(to_mmr_wdata), .o_mmr_ren(to_mmr_ren),
    .i_mmr_rdata(mmr_rdata), .i_mmr_waddr_error(waddr_error), .i_mmr_raddr_error(raddr_error),
    .o_core_start(to_core_start), .i_core_done(to_core_done), .i_abort(1'b0), .o_busy(to_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MMR slave and core model
  logic [11:0] inj_addr = 12'hFFF;
  logic [31:0] rd_value = '0;
  int          done_delay = 0;
  int          dcnt = 0;
  always @(posedge clk) begin
    waddr_error <= mmr_wen && (mmr_addr == inj_addr);
    raddr_error <= 1'b0;
    if (mmr_ren || to_mmr_ren) mmr_rdata <= rd_value;
    if (core_start) dcnt <= 1;
    else if (dcnt != 0) dcnt <= dcnt + 1;
  end
  assign core_done = (done_delay != 0) && (dcnt == done_delay);

  // event logger for the main instance (mid-cycle sampling)
  logic [11:0] wl_addr [64];
  logic [31:0] wl_data [64];
  int          wl_cyc  [64];
  int wcnt = 0, start_cnt = 0, start_cyc = 0, ren_cnt = 0, ren_cyc = 0, done_cyc = 0, rsp_cyc = 0;
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (mmr_wen && wcnt < 64) begin
      wl_addr[wcnt] = mmr_addr;
      wl_data[wcnt] = mmr_wdata;
      wl_cyc[wcnt]  = cyc;
      wcnt++;
    end
    if (core_start) begin start_cnt++; start_cyc = cyc; end
    if (mmr_ren) begin ren_cnt++; ren_cyc = cyc; end
    if (core_done) done_cyc = cyc;
    if (rsp_valid && !prev_rv) rsp_cyc = cyc;
    prev_rv = rsp_valid;
  end

  int tests = 0, fails = 0;
  int t_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [31:0] c, input logic [31:0] h, input logic [31:0] l);
    job_count = c; job_hi = h; job_lo = l;
    job_valid = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int max);
    int n = 0;
    while (!rsp_valid && n < max) begin @(negedge clk); n++; end
    #1;
    chk(tag, {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, job_ready}, 32'd1);
  endtask

  task automatic chk_writes(input string tag, input int base, input logic [31:0] c,
                            input logic [31:0] h, input logic [31:0] l, input int t);
    logic [11:0] ea [3];
    logic [31:0] ed [3];
    ea[0] = 12'h010; ea[1] = 12'h014; ea[2] = 12'h018;
    ed[0] = c; ed[1] = h; ed[2] = l;
    chk({tag, "_wr_count"}, wcnt - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_wr_addr"}, {20'd0, wl_addr[(base + i) % 64]}, {20'd0, ea[i]});
      chk({tag, "_wr_data"}, wl_data[(base + i) % 64], ed[i]);
      chk({tag, "_wr_cycle"}, wl_cyc[(base + i) % 64], t + 1 + i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, s, n, ren_before, saw, t2;

    // ---------------- reset state
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_job_ready", {31'd0, job_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_status", {30'd0, rsp_status}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_mmr_wen", {31'd0, mmr_wen}, 32'd0);
    chk("rst_mmr_ren", {31'd0, mmr_ren}, 32'd0);
    chk("rst_mmr_addr", {20'd0, mmr_addr}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    arst_n = 1'b1;
    @(negedge clk);

    // ---------------- 1: nominal job
    rd_value = 32'h2A; done_delay = 10;
    base = wcnt;
    send_job(32'd5, 32'h100, 32'h200);
    chk("t1_ready_low", {31'd0, job_ready}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_rsp("t1_rsp_seen", 60);
    chk_writes("t1", base, 32'd5, 32'h100, 32'h200, t_acc);
    chk("t1_start_cycle", start_cyc, t_acc + 5);
    chk("t1_ren_cycle", ren_cyc, done_cyc + 1);
    chk("t1_rsp_cycle", rsp_cyc, done_cyc + 3);
    chk("t1_status", {30'd0, rsp_status}, 32'd0);
    chk("t1_result", rsp_result, 32'h2A);
    chk("t1_idle_addr", {20'd0, mmr_addr}, 32'd0);
    chk("t1_idle_wdata", mmr_wdata, 32'd0);
    handshake("t1");

    // ---------------- 2: write error on the 0x14 write
    inj_addr = 12'h014; done_delay = 4;
    s = start_cnt;
    send_job(32'd1, 32'd2, 32'd3);
    wait_rsp("t2_rsp_seen", 30);
    chk("t2_no_start", start_cnt, s);
    chk("t2_rsp_cycle", rsp_cyc, t_acc + 5);
    chk("t2_status", {30'd0, rsp_status}, 32'd1);
    chk("t2_result", rsp_result, 32'd0);
    handshake("t2");
    inj_addr = 12'hFFF;

    // ---------------- 3: timeout on the TIMEOUT_CYCLES=8 instance
    to_job_valid = 1'b1;
    @(negedge clk);
    to_job_valid = 1'b0;
    n = 0;
    while (!to_core_start && n < 20) begin @(negedge clk); n++; end
    chk("t3_start_seen", {31'd0, to_core_start}, 32'd1);
    s = cyc;
    n = 0;
    while (!to_rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk("t3_rsp_seen", {31'd0, to_rsp_valid}, 32'd1);
    chk("t3_rsp_delay", cyc - s, 32'd9);
    chk("t3_status", {30'd0, to_rsp_status}, 32'd2);
    chk("t3_result", to_rsp_result, 32'd0);
    to_rsp_ready = 1'b1;
    @(negedge clk);
    to_rsp_ready = 1'b0;
    chk("t3_ready_back", {31'd0, to_job_ready}, 32'd1);

    // ---------------- 3b: done in the last allowed WAIT_DONE cycle wins over timeout
    rd_value = 32'hBEEF;
    to_job_valid = 1'b1;
    @(negedge clk);
    to_job_valid = 1'b0;
    n = 0;
    while (!to_core_start && n < 20) begin @(negedge clk); n++; end
    s = cyc;
    repeat (8) @(negedge clk);
    to_core_done = 1'b1;
    @(negedge clk);
    to_core_done = 1'b0;
    n = 0;
    while (!to_rsp_valid && n < 30) begin @(negedge clk); n++; end
    chk("t3b_rsp_delay", cyc - s, 32'd11);
    chk("t3b_status", {30'd0, to_rsp_status}, 32'd0);
    chk("t3b_result", to_rsp_result, 32'hBEEF);
    to_rsp_ready = 1'b1;
    @(negedge clk);
    to_rsp_ready = 1'b0;

    // ---------------- 4: response backpressure with a pending second job
    rd_value = 32'h55; done_delay = 3;
    send_job(32'd7, 32'd8, 32'd9);
    wait_rsp("t4a_rsp_seen", 40);
    job_count = 32'h11; job_hi = 32'h22; job_lo = 32'h33;
    job_valid = 1'b1;
    rd_value = 32'h77;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("t4_hold_result", rsp_result, 32'h55);
      chk("t4_hold_status", {30'd0, rsp_status}, 32'd0);
      chk("t4_hold_ready_low", {31'd0, job_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    t2 = cyc;
    base = wcnt;
    chk("t4_rsp_cleared", {31'd0, rsp_valid}, 32'd0);
    chk("t4_ready_back", {31'd0, job_ready}, 32'd1);
    @(negedge clk);
    job_valid = 1'b0;
    chk("t4_job2_accepted", {31'd0, busy}, 32'd1);
    wait_rsp("t4b_rsp_seen", 40);
    chk_writes("t4b", base, 32'h11, 32'h22, 32'h33, t2);
    chk("t4b_result", rsp_result, 32'h77);
    handshake("t4b");

    // ---------------- 5: abort in WAIT_DONE, coinciding with core_done
    done_delay = 3;
    ren_before = ren_cnt;
    send_job(32'd4, 32'd5, 32'd6);
    n = 0;
    while (!core_start && n < 20) begin @(negedge clk); n++; end
    chk("t5_start_seen", {31'd0, core_start}, 32'd1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("t5_idle_ready", {31'd0, job_ready}, 32'd1);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    chk("t5_no_read", ren_cnt, ren_before);
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) saw++;
    end
    chk("t5_no_rsp", saw, 32'd0);
    rd_value = 32'h99; done_delay = 4;
    send_job(32'd1, 32'd1, 32'd1);
    wait_rsp("t5b_rsp_seen", 40);
    chk("t5b_status", {30'd0, rsp_status}, 32'd0);
    chk("t5b_result", rsp_result, 32'h99);
    handshake("t5b");

    // ---------------- 6: async reset during WR_HI
    send_job(32'hA, 32'hB, 32'hC);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_wen", {31'd0, mmr_wen}, 32'd0);
    chk("t6_rst_addr", {20'd0, mmr_addr}, 32'd0);
    chk("t6_rst_wdata", mmr_wdata, 32'd0);
    chk("t6_rst_ready", {31'd0, job_ready}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    rd_value = 32'h33; done_delay = 2;
    base = wcnt;
    send_job(32'hD, 32'hE, 32'hF);
    wait_rsp("t6b_rsp_seen", 40);
    chk_writes("t6b", base, 32'hD, 32'hE, 32'hF, t_acc);
    chk("t6b_status", {30'd0, rsp_status}, 32'd0);
    chk("t6b_result", rsp_result, 32'h33);
    handshake("t6b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
